// File: rtl/hacd_pkg.sv
// Shared types and constants for the hawk page-write datapath.
//   axi_wr_reqpkt_t  : page-write request (addr, 512-bit data, strobes, valids)
//   axi_wr_rdypkt_t  : AW/W ready toward the page-write manager
//   axi_wr_resppkt_t : write-completion pulse
package hacd_pkg;

    localparam int unsigned BLK_SIZE = 64;
    localparam int unsigned ADDR_W   = 64;
    localparam int unsigned DATA_W   = BLK_SIZE * 8;
    localparam int unsigned STRB_W   = BLK_SIZE;
    localparam int unsigned OFFS_W   = $clog2(BLK_SIZE);

    localparam logic [2:0] AXI_SIZE_64B    = 3'b110;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_SEND   = 2'd1,
        WR_WAIT_B = 2'd2
    } axi_wr_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              awvalid;
        logic              wvalid;
    } axi_wr_reqpkt_t;

    typedef struct packed {
        logic awready;
        logic wready;
    } axi_wr_rdypkt_t;

    typedef struct packed {
        logic bresp;
    } axi_wr_resppkt_t;

endpackage

// File: rtl/hawk_axi_wr_master.sv
// Single-outstanding AXI4 write master: turns one page-write request into one
// 512-bit single-beat AW/W pair and reports completion from the B channel.
// Ports:
//   clk_i, rst_ni            : clock, async active-low reset
//   req_i / rdy_o            : request packet in, AW/W ready out (page-write manager)
//   resp_o / err_o           : completion pulse, error pulse (bad BRESP, bad BID, misalign)
//   busy_o                   : transaction in flight
//   m_aw* / m_w* / m_b*      : AXI4 AW, W and B channels (memory side)
module hawk_axi_wr_master
    import hacd_pkg::*;
#(
    parameter int unsigned          AXI_ID_W       = 4,
    parameter logic [AXI_ID_W-1:0]  AXI_ID         = '0,
    parameter bit                   ADDR_ALIGN_CHK = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  axi_wr_reqpkt_t        req_i,
    output axi_wr_rdypkt_t        rdy_o,
    output axi_wr_resppkt_t       resp_o,
    output logic                  err_o,
    output logic                  busy_o,

    output logic [AXI_ID_W-1:0]   m_awid,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic [7:0]            m_awlen,
    output logic [2:0]            m_awsize,
    output logic [1:0]            m_awburst,
    output logic                  m_awvalid,
    input  logic                  m_awready,

    output logic [DATA_W-1:0]     m_wdata,
    output logic [STRB_W-1:0]     m_wstrb,
    output logic                  m_wlast,
    output logic                  m_wvalid,
    input  logic                  m_wready,

    input  logic [AXI_ID_W-1:0]   m_bid,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready
);

    axi_wr_state_e state_q, state_d;

    logic              rdy_q,     rdy_d;
    logic              resp_q,    resp_d;
    logic              err_q,     err_d;
    logic              busy_q,    busy_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q,  wvalid_d;
    logic              bready_q,  bready_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q,  w_done_d;

    logic [ADDR_W-1:0] awaddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic              accept_c;
    logic              misalign_c;
    logic [ADDR_W-1:0] req_addr_c;
    logic              aw_hs_c;
    logic              w_hs_c;
    logic              aw_done_c;
    logic              w_done_c;
    logic              b_hs_c;
    logic              b_err_c;

    // Handshake and request qualification.
    always_comb begin
        accept_c   = (state_q == WR_IDLE) && rdy_q && req_i.awvalid && req_i.wvalid;
        misalign_c = ADDR_ALIGN_CHK && (req_i.addr[OFFS_W-1:0] != OFFS_W'(0));
        req_addr_c = req_i.addr;
        if (ADDR_ALIGN_CHK) begin
            req_addr_c = {req_i.addr[ADDR_W-1:OFFS_W], OFFS_W'(0)};
        end
        aw_hs_c    = awvalid_q && m_awready;
        w_hs_c     = wvalid_q && m_wready;
        // The second handshake counts as done in the cycle it happens.
        aw_done_c  = aw_done_q || aw_hs_c;
        w_done_c   = w_done_q || w_hs_c;
        b_hs_c     = m_bvalid && bready_q;
        b_err_c    = (m_bresp == AXI_RESP_SLVERR) || (m_bresp == AXI_RESP_DECERR) ||
                     (m_bid != AXI_ID);
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= WR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WR_IDLE: begin
                if (accept_c) begin
                    state_d = WR_SEND;
                end
            end
            WR_SEND: begin
                if (aw_done_c && w_done_c) begin
                    state_d = WR_WAIT_B;
                end
            end
            WR_WAIT_B: begin
                if (b_hs_c) begin
                    state_d = WR_IDLE;
                end
            end
            default: state_d = WR_IDLE;
        endcase
    end

    // Next values of the registered outputs and handshake flags.
    always_comb begin
        rdy_d     = 1'b0;
        resp_d    = 1'b0;
        err_d     = 1'b0;
        busy_d    = (state_d != WR_IDLE);
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = (state_d == WR_WAIT_B);
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;

        unique case (state_q)
            WR_IDLE: begin
                // Ready is held low for one cycle after returning to IDLE.
                rdy_d = !accept_c;
                if (accept_c) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    err_d     = misalign_c;
                end
            end
            WR_SEND: begin
                if (aw_hs_c) begin
                    awvalid_d = 1'b0;
                end
                if (w_hs_c) begin
                    wvalid_d = 1'b0;
                end
                aw_done_d = (state_d == WR_SEND) && aw_done_c;
                w_done_d  = (state_d == WR_SEND) && w_done_c;
            end
            WR_WAIT_B: begin
                if (b_hs_c) begin
                    resp_d = 1'b1;
                    err_d  = b_err_c;
                end
            end
            default: begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
            end
        endcase
    end

    // Control output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdy_q     <= 1'b0;
            resp_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            rdy_q     <= rdy_d;
            resp_q    <= resp_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Payload capture; held stable until the next accepted request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else if (accept_c) begin
            awaddr_q <= req_addr_c;
            wdata_q  <= req_i.data;
            wstrb_q  <= req_i.strb;
        end
    end

    assign rdy_o.awready = rdy_q;
    assign rdy_o.wready  = rdy_q;
    assign resp_o.bresp  = resp_q;
    assign err_o         = err_q;
    assign busy_o        = busy_q;

    assign m_awid    = AXI_ID;
    assign m_awaddr  = awaddr_q;
    assign m_awlen   = 8'd0;
    assign m_awsize  = AXI_SIZE_64B;
    assign m_awburst = AXI_BURST_INCR;
    assign m_awvalid = awvalid_q;

    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_wlast   = 1'b1;
    assign m_wvalid  = wvalid_q;

    assign m_bready  = bready_q;

endmodule

// File: doc/hawk_axi_wr_master.md
Name: hawk_axi_wr_master

Overview:
Converts page-write requests from hawk_pgwr_mngr, carried as hacd_pkg::axi_wr_reqpkt_t, into single-beat 512-bit AXI4 write transactions toward the memory-side interconnect. It sits directly downstream of the page-write manager. It returns ready and write-completion status through axi_wr_rdypkt_t and axi_wr_resppkt_t. It supports one outstanding transaction and decouples the AW and W channel handshakes.

Parameters:
AXI_ID_W, 4, width of awid/bid
AXI_ID, 0, constant ID driven on awid
ADDR_ALIGN_CHK, 1, when 1, a request addr with addr[5:0]!=0 is flagged as err and sent with addr[5:0] forced to 0

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  642  hacd_pkg::axi_wr_reqpkt_t {addr[63:0], data[511:0], strb[63:0], awvalid, wvalid}
rdy_o  out  2  hacd_pkg::axi_wr_rdypkt_t {awready, wready} toward the page-write manager
resp_o  out  1  hacd_pkg::axi_wr_resppkt_t; bresp pulses for 1 cycle on write completion
err_o  out  1  1-cycle pulse: BRESP was SLVERR/DECERR, or the address was misaligned
busy_o  out  1  high while a transaction is in flight
m_awid/awaddr/awlen/awsize/awburst/awvalid  out  AXI_ID_W/64/8/3/2/1  AXI AW channel
m_awready  in  1
m_wdata/wstrb/wlast/wvalid  out  512/64/1/1  AXI W channel
m_wready  in  1
m_bid/bresp/bvalid  in  AXI_ID_W/2/1  AXI B channel
m_bready  out  1

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: all valids, rdy_o, resp_o, err_o, busy_o and m_bready are 0; the state is IDLE.
- Constant outputs: awlen=0, awsize=3'b110 (64 B), awburst=INCR (2'b01), wlast=1, awid=AXI_ID.
- Outputs m_aw*/m_w* are driven from registers; there are no combinational paths from the AXI inputs to the AXI outputs.
- FSM states: IDLE, SEND, WAIT_B.
- IDLE:
  - rdy_o.awready=rdy_o.wready=1.
  - The block accepts a request in a cycle where req_i.awvalid && req_i.wvalid are both 1. A single valid alone is ignored.
  - On accept it latches addr/data/strb, asserts m_awvalid and m_wvalid the next cycle, and moves to SEND.
  - Misaligned addr with ADDR_ALIGN_CHK=1: err_o pulses in the accept+1 cycle and the write proceeds aligned.
- SEND:
  - rdy_o is 0.
  - Separate aw_done and w_done flags are set on m_awvalid&&m_awready and on m_wvalid&&m_wready respectively.
  - Each valid drops the cycle after its own handshake. Valids are never withdrawn before their handshake, and payloads stay stable.
  - Both handshakes may complete in the same cycle, or in either order.
  - When both are done (including the cycle the second completes), the next state is WAIT_B and m_bready=1.
- WAIT_B:
  - The transaction completes on m_bvalid && m_bready. The block then drops m_bready, pulses resp_o.bresp for 1 cycle, and returns to IDLE.
  - err_o pulses in the same cycle when m_bresp[1]=1.
  - If m_bid != AXI_ID, err_o is pulsed as well, and completion still occurs.
- Back-to-back: rdy_o rises in the cycle after the return to IDLE. The minimum cycle-to-cycle request spacing is 4 clocks.
- busy_o = (state != IDLE).
- Reset mid-transaction: the FSM returns to IDLE immediately and the in-flight write is abandoned. The AXI slave side is assumed to be reset together with this block.

Decomposition:
- Reuse hacd_pkg: axi_wr_reqpkt_t, axi_wr_rdypkt_t, axi_wr_resppkt_t, BLK_SIZE.
- Add to hacd_pkg:
  - AXI_SIZE_64B=3'b110
  - AXI_BURST_INCR=2'b01
  - AXI_RESP_OKAY=2'b00
  - typedef enum logic[1:0] {WR_IDLE, WR_SEND, WR_WAIT_B} axi_wr_state_e
- No sub-module is needed. The AW/W done-flag tracking stays inline.

Test Plan:
- Single write, slave always ready:
  - Stimulus: req addr=0xFFF61000C0, data pattern 0xA5.., strb all ones, bresp=OKAY.
  - Required: exactly one AW and one W beat with awaddr=0xFFF61000C0, awsize=6, wlast=1; resp_o.bresp pulses once; err_o=0; rdy_o returns high.
- Skewed handshakes:
  - Stimulus: awready delayed 5 cycles; wready immediate.
  - Required: the W beat completes first, wvalid drops, awvalid holds with a stable addr until accepted; WAIT_B is entered only after the AW handshake.
- Reverse skew:
  - Stimulus: wready delayed 3 cycles after AW accept.
  - Required: wdata/wstrb are stable throughout; a single B completion.
- Error response:
  - Stimulus: bresp=2'b10 (SLVERR).
  - Required: err_o and resp_o.bresp pulse in the same cycle; the FSM returns to IDLE.
- Misaligned address:
  - Stimulus: addr=0x...1004.
  - Required: err_o pulses 1 cycle after accept; awaddr=0x...1000.
- Reset mid-SEND, and partial valid:
  - Stimulus: assert rst_ni=0 while awvalid=1; separately drive req with awvalid=1, wvalid=0.
  - Required: all outputs are 0 asynchronously and the FSM is in IDLE; the partial-valid request is not accepted (no AW issued).
